// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station feeding the ALU execute stage.
// Holds up to DEPTH dispatched micro-ops in a collapsing queue (index 0 oldest).
// It snoops the writeback broadcast to unlock operand tags, and each cycle it
// issues the oldest entry whose tags are all TAG_UNLOCKED into a registered
// ALU input.
//
// Optional build macro: ALU_RS_WAKE_BYPASS_EN. When it is defined, readiness
// also counts the same-cycle wakeup, so a wakeup can lead to issue one cycle
// later instead of two.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   rdy              global ready; low freezes all state
//   flush            drop every entry and any pending issue
//   disp_*           dispatch request/handshake and micro-op fields
//   wb_en/tag/data   writeback broadcast used for wakeup
//   alu_free         ALU can accept a new op
//   iss_*            registered ALU input; iss_busy pulses once per issue
//   count            number of occupied entries
module alu_rs #(
  parameter int unsigned       DEPTH        = 4,
  parameter int unsigned       TAG_W        = 4,
  parameter int unsigned       OP_W         = 6,
  parameter logic [TAG_W-1:0]  TAG_UNLOCKED = {TAG_W{1'b1}},
  localparam int unsigned      CW           = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [31:0]      disp_pc,
  input  logic [TAG_W-1:0] disp_tagx,
  input  logic [TAG_W-1:0] disp_tagy,
  input  logic [TAG_W-1:0] disp_tagw,
  input  logic [31:0]      disp_datax,
  input  logic [31:0]      disp_datay,
  input  logic [4:0]       disp_target,
  input  logic             wb_en,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_data,
  input  logic             alu_free,
  output logic             iss_busy,
  output logic [OP_W-1:0]  iss_op,
  output logic [31:0]      iss_pc,
  output logic [TAG_W-1:0] iss_tagx,
  output logic [TAG_W-1:0] iss_tagy,
  output logic [TAG_W-1:0] iss_tagw,
  output logic [31:0]      iss_datax,
  output logic [31:0]      iss_datay,
  output logic [4:0]       iss_target,
  output logic [CW-1:0]    count
);

  typedef struct packed {
    logic             v;
    logic [OP_W-1:0]  op;
    logic [31:0]      pc;
    logic [TAG_W-1:0] tx;
    logic [31:0]      dx;
    logic [TAG_W-1:0] ty;
    logic [31:0]      dy;
    logic [TAG_W-1:0] tw;
    logic [4:0]       tgt;
  } entry_t;

  localparam logic [CW-1:0] CntOne   = CW'(1);
  localparam logic [CW-1:0] CntDepth = CW'(DEPTH);

  entry_t          ent_q [DEPTH];
  entry_t          woke  [DEPTH];
  entry_t          ent_d [DEPTH];
  entry_t          disp_ent;
  entry_t          pick;
  logic [DEPTH-1:0] ready;
  logic            found;
  int              sel;
  logic            do_issue;
  logic            do_disp;
  logic [CW-1:0]   widx;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            iss_busy_q;
  logic [OP_W-1:0] iss_op_q;
  logic [31:0]     iss_pc_q, iss_dx_q, iss_dy_q;
  logic [4:0]      iss_tgt_q;

  // A broadcast of TAG_UNLOCKED never matches anything.
  function automatic logic wb_hit(input logic en, input logic [TAG_W-1:0] wtag,
                                  input logic [TAG_W-1:0] t);
    return en && (wtag != TAG_UNLOCKED) && (t == wtag);
  endfunction

  assign disp_ready = (cnt_q < CntDepth);
  assign count      = cnt_q;
  assign do_disp    = disp_valid && disp_ready && rdy && !flush;

  always_comb begin
    // Entries as they look after this cycle's wakeup.
    for (int i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (ent_q[i].v) begin
        if (wb_hit(wb_en, wb_tag, ent_q[i].tx)) begin
          woke[i].tx = TAG_UNLOCKED;
          woke[i].dx = wb_data;
        end
        if (wb_hit(wb_en, wb_tag, ent_q[i].ty)) begin
          woke[i].ty = TAG_UNLOCKED;
          woke[i].dy = wb_data;
        end
        if (wb_hit(wb_en, wb_tag, ent_q[i].tw)) woke[i].tw = TAG_UNLOCKED;
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
`ifdef ALU_RS_WAKE_BYPASS_EN
      ready[i] = woke[i].v && (woke[i].tx == TAG_UNLOCKED) &&
                 (woke[i].ty == TAG_UNLOCKED) && (woke[i].tw == TAG_UNLOCKED);
`else
      ready[i] = ent_q[i].v && (ent_q[i].tx == TAG_UNLOCKED) &&
                 (ent_q[i].ty == TAG_UNLOCKED) && (ent_q[i].tw == TAG_UNLOCKED);
`endif
    end

    // Oldest ready entry. Its woken fields equal its registered ones unless
    // the bypass made it ready this cycle.
    found = 1'b0;
    sel   = 0;
    pick  = woke[0];
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && ready[i]) begin
        found = 1'b1;
        sel   = i;
        pick  = woke[i];
      end
    end
    do_issue = rdy && !flush && alu_free && found;

    // Collapse over the issued slot.
    for (int i = 0; i < DEPTH - 1; i++) begin
      ent_d[i] = (do_issue && (i >= sel)) ? woke[i+1] : woke[i];
    end
    ent_d[DEPTH-1] = do_issue ? '0 : woke[DEPTH-1];

    // New entry, capturing a matching same-cycle writeback.
    disp_ent.v   = 1'b1;
    disp_ent.op  = disp_op;
    disp_ent.pc  = disp_pc;
    disp_ent.tx  = disp_tagx;
    disp_ent.dx  = disp_datax;
    disp_ent.ty  = disp_tagy;
    disp_ent.dy  = disp_datay;
    disp_ent.tw  = disp_tagw;
    disp_ent.tgt = disp_target;
    if (wb_hit(wb_en, wb_tag, disp_tagx)) begin
      disp_ent.tx = TAG_UNLOCKED;
      disp_ent.dx = wb_data;
    end
    if (wb_hit(wb_en, wb_tag, disp_tagy)) begin
      disp_ent.ty = TAG_UNLOCKED;
      disp_ent.dy = wb_data;
    end
    if (wb_hit(wb_en, wb_tag, disp_tagw)) disp_ent.tw = TAG_UNLOCKED;

    widx = do_issue ? (cnt_q - CntOne) : cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (do_disp && (int'(widx) == i)) ent_d[i] = disp_ent;
    end

    cnt_d = cnt_q;
    if (do_disp && !do_issue)      cnt_d = cnt_q + CntOne;
    else if (!do_disp && do_issue) cnt_d = cnt_q - CntOne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q      <= '0;
      iss_busy_q <= 1'b0;
      iss_op_q   <= '0;
      iss_pc_q   <= '0;
      iss_dx_q   <= '0;
      iss_dy_q   <= '0;
      iss_tgt_q  <= '0;
    end else if (rdy) begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        cnt_q      <= '0;
        iss_busy_q <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        cnt_q      <= cnt_d;
        iss_busy_q <= do_issue;
        if (do_issue) begin
          iss_op_q  <= pick.op;
          iss_pc_q  <= pick.pc;
          iss_dx_q  <= pick.dx;
          iss_dy_q  <= pick.dy;
          iss_tgt_q <= pick.tgt;
        end
      end
    end
  end

  assign iss_busy   = iss_busy_q;
  assign iss_op     = iss_op_q;
  assign iss_pc     = iss_pc_q;
  assign iss_datax  = iss_dx_q;
  assign iss_datay  = iss_dy_q;
  assign iss_target = iss_tgt_q;
  // Only fully unlocked entries issue, so the issued tags are constant.
  assign iss_tagx   = TAG_UNLOCKED;
  assign iss_tagy   = TAG_UNLOCKED;
  assign iss_tagw   = TAG_UNLOCKED;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned OP_W  = 6;
  localparam logic [3:0]  UNL   = 4'hF;

  logic             clk = 1'b0;
  logic             rst_n, rdy, flush, disp_valid, disp_ready;
  logic [OP_W-1:0]  disp_op;
  logic [31:0]      disp_pc, disp_datax, disp_datay, wb_data;
  logic [TAG_W-1:0] disp_tagx, disp_tagy, disp_tagw, wb_tag;
  logic [4:0]       disp_target;
  logic             wb_en, alu_free, iss_busy;
  logic [OP_W-1:0]  iss_op;
  logic [31:0]      iss_pc, iss_datax, iss_datay;
  logic [TAG_W-1:0] iss_tagx, iss_tagy, iss_tagw;
  logic [4:0]       iss_target;
  logic [2:0]       count;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [31:0]     pc;
    logic [31:0]     dx;
    logic [31:0]     dy;
    logic [4:0]      tgt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .TAG_UNLOCKED(UNL)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_pc(disp_pc), .disp_tagx(disp_tagx), .disp_tagy(disp_tagy),
    .disp_tagw(disp_tagw), .disp_datax(disp_datax), .disp_datay(disp_datay),
    .disp_target(disp_target), .wb_en(wb_en), .wb_tag(wb_tag), .wb_data(wb_data),
    .alu_free(alu_free), .iss_busy(iss_busy), .iss_op(iss_op), .iss_pc(iss_pc),
    .iss_tagx(iss_tagx), .iss_tagy(iss_tagy), .iss_tagw(iss_tagw),
    .iss_datax(iss_datax), .iss_datay(iss_datay), .iss_target(iss_target),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [31:0] pc,
                      input logic [3:0] tx, input logic [31:0] dx,
                      input logic [3:0] ty, input logic [31:0] dy,
                      input logic [3:0] tw, input logic [4:0] tgt);
    disp_valid  = 1'b1;
    disp_op     = op;
    disp_pc     = pc;
    disp_tagx   = tx;
    disp_datax  = dx;
    disp_tagy   = ty;
    disp_datay  = dy;
    disp_tagw   = tw;
    disp_target = tgt;
  endtask

  task automatic push(input logic [OP_W-1:0] op, input logic [31:0] pc,
                      input logic [31:0] dx, input logic [31:0] dy, input logic [4:0] tgt);
    exp_t e;
    e.op = op; e.pc = pc; e.dx = dx; e.dy = dy; e.tgt = tgt;
    sb.push_back(e);
  endtask

  // Scoreboard: every issue pulse must match the next expected op.
  always @(negedge clk) begin
    if (rst_n && iss_busy) begin
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL spurious_issue observed_pc=%0h expected=none", iss_pc);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_op", 64'(iss_op), 64'(e.op));
        chk("sb_pc", 64'(iss_pc), 64'(e.pc));
        chk("sb_datax", 64'(iss_datax), 64'(e.dx));
        chk("sb_datay", 64'(iss_datay), 64'(e.dy));
        chk("sb_target", 64'(iss_target), 64'(e.tgt));
        chk("sb_tags", 64'({iss_tagx, iss_tagy, iss_tagw}), 64'({UNL, UNL, UNL}));
      end
    end
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; alu_free = 1'b1;
    disp_valid = 1'b0; disp_op = '0; disp_pc = '0; disp_tagx = UNL; disp_tagy = UNL;
    disp_tagw = UNL; disp_datax = '0; disp_datay = '0; disp_target = '0;
    wb_en = 1'b0; wb_tag = UNL; wb_data = '0;
    step(); step();
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_disp_ready", 64'(disp_ready), 64'd1);
    chk("rst_iss_busy", 64'(iss_busy), 64'd0);
    chk("rst_iss_data", 64'({iss_pc, iss_datax}), 64'd0);
    chk("rst_iss_tagx", 64'(iss_tagx), 64'(UNL));
    rst_n = 1'b1;
    step();

    // Unlocked op: accept, then issue two edges after being driven.
    disp(6'd1, 32'h100, UNL, 32'd5, UNL, 32'd7, UNL, 5'd3);
    push(6'd1, 32'h100, 32'd5, 32'd7, 5'd3);
    step();
    disp_valid = 1'b0;
    chk("t1_not_early", 64'(iss_busy), 64'd0);
    chk("t1_count1", 64'(count), 64'd1);
    step();
    chk("t1_busy", 64'(iss_busy), 64'd1);
    chk("t1_count0", 64'(count), 64'd0);
    step();
    chk("t1_pulse", 64'(iss_busy), 64'd0);

    // Younger ready op passes an older locked one.
    disp(6'd2, 32'h200, 4'd3, 32'd0, UNL, 32'd9, UNL, 5'd4);
    step();
    disp(6'd3, 32'h204, UNL, 32'd1, UNL, 32'd2, UNL, 5'd5);
    push(6'd3, 32'h204, 32'd1, 32'd2, 5'd5);
    step();
    disp_valid = 1'b0;
    step();
    chk("t2_b_first", 64'(iss_pc), 64'h204);
    chk("t2_count", 64'(count), 64'd1);
    wb_en = 1'b1; wb_tag = 4'd3; wb_data = 32'h10;
    push(6'd2, 32'h200, 32'h10, 32'd9, 5'd4);
    step();
    wb_en = 1'b0;
`ifdef ALU_RS_WAKE_BYPASS_EN
    chk("t2_a_wake1", 64'(iss_busy), 64'd1);
    step();
`else
    chk("t2_a_wake1", 64'(iss_busy), 64'd0);
    step();
    chk("t2_a_wake2", 64'(iss_busy), 64'd1);
    chk("t2_a_datax", 64'(iss_datax), 64'h10);
`endif
    chk("t2_empty", 64'(count), 64'd0);
    step();

    // Fill to capacity with locked ops, then release them together.
    for (int i = 0; i < 4; i++) begin
      disp(6'd4, 32'h300 + 32'(4 * i), 4'd2, 32'd0, UNL, 32'(i), UNL, 5'(i));
      push(6'd4, 32'h300 + 32'(4 * i), 32'h22, 32'(i), 5'(i));
      step();
    end
    chk("t3_full_count", 64'(count), 64'd4);
    chk("t3_not_ready", 64'(disp_ready), 64'd0);
    disp(6'd9, 32'h999, UNL, 32'd0, UNL, 32'd0, UNL, 5'd9);
    step();
    disp_valid = 1'b0;
    chk("t3_extra_ignored", 64'(count), 64'd4);
    wb_en = 1'b1; wb_tag = 4'd2; wb_data = 32'h22;
    step();
    wb_en = 1'b0;
    step();
`ifdef ALU_RS_WAKE_BYPASS_EN
    chk("t3_after_first", 64'(count), 64'd2);
`else
    chk("t3_after_first", 64'(count), 64'd3);
`endif
    chk("t3_ready_again", 64'(disp_ready), 64'd1);
    step(); step(); step(); step();
    chk("t3_drained", 64'(count), 64'd0);
    chk("t3_idle", 64'(iss_busy), 64'd0);

    // Dispatch captures a same-cycle writeback.
    disp(6'd5, 32'h190, UNL, 32'h11, 4'd6, 32'd0, UNL, 5'd7);
    wb_en = 1'b1; wb_tag = 4'd6; wb_data = 32'hAB;
    push(6'd5, 32'h190, 32'h11, 32'hAB, 5'd7);
    step();
    disp_valid = 1'b0; wb_en = 1'b0;
    step();
    chk("t4_busy", 64'(iss_busy), 64'd1);
    chk("t4_datay", 64'(iss_datay), 64'hAB);
    step();

    // Flush beats a simultaneous dispatch; woken entries must not reappear.
    for (int i = 0; i < 3; i++) begin
      disp(6'd6, 32'h500 + 32'(i), 4'd7, 32'd0, UNL, 32'd0, UNL, 5'd1);
      step();
    end
    chk("t5_count3", 64'(count), 64'd3);
    disp(6'd6, 32'h5FF, UNL, 32'd0, UNL, 32'd0, UNL, 5'd1);
    flush = 1'b1;
    step();
    flush = 1'b0; disp_valid = 1'b0;
    chk("t5_flush_count", 64'(count), 64'd0);
    chk("t5_flush_busy", 64'(iss_busy), 64'd0);
    wb_en = 1'b1; wb_tag = 4'd7; wb_data = 32'h77;
    step();
    wb_en = 1'b0;
    step(); step();
    chk("t5_still_empty", 64'(count), 64'd0);

    // Freeze with a ready entry, then resume.
    disp(6'd7, 32'h600, UNL, 32'd3, UNL, 32'd4, UNL, 5'd8);
    step();
    disp_valid = 1'b0;
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_frozen_busy", 64'(iss_busy), 64'd0);
      chk("t6_frozen_count", 64'(count), 64'd1);
      chk("t6_held_pc", 64'(iss_pc), 64'h190);
    end
    rdy = 1'b1;
    push(6'd7, 32'h600, 32'd3, 32'd4, 5'd8);
    step();
    chk("t6_resume", 64'(iss_pc), 64'h600);
    step();

    // Reset mid-operation clears outputs immediately.
    disp(6'd8, 32'h700, UNL, 32'd1, UNL, 32'd1, UNL, 5'd2);
    step();
    disp(6'd8, 32'h704, UNL, 32'd1, UNL, 32'd1, UNL, 5'd2);
    step();
    disp_valid = 1'b0;
    chk("t7_pre_rst_pc", 64'(iss_pc), 64'h700);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", 64'(iss_busy), 64'd0);
    chk("t7_rst_count", 64'(count), 64'd0);
    chk("t7_rst_pc", 64'(iss_pc), 64'd0);
    chk("t7_rst_ready", 64'(disp_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t7_post_count", 64'(count), 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
ALU reservation station sitting directly upstream of the ALU execute stage, between the dispatcher/allocator and ex_alu. Buffers up to DEPTH dispatched ALU/jump micro-ops and snoops the writeback broadcast to resolve locked operand tags. Issues the oldest fully-ready entry, with all tags UNLOCKED, into the ALU's one-cycle input register.

Parameters:
DEPTH, 4, number of entries (2..8)
TAG_W, 4, regtag width
OP_W, 6, sinst width
TAG_UNLOCKED, 4'hF, tag value meaning "operand present"

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rdy  in  1  global ready; low = freeze
flush  in  1  discard all entries and pending issue (jump redirect)
disp_valid  in  1  dispatch request
disp_ready  out  1  station not full
disp_op  in  OP_W  micro-op
disp_pc  in  32  instruction pc
disp_tagx / disp_tagy / disp_tagw  in  TAG_W  each  operand/dest lock tags
disp_datax / disp_datay  in  32  each  operand values (valid when tag unlocked)
disp_target  in  5  destination register
wb_en  in  1  writeback broadcast valid
wb_tag  in  TAG_W  producing tag
wb_data  in  32  produced value
alu_free  in  1  ALU can accept (not busy)
iss_busy  out  1  ALU input valid (one-cycle pulse per issue)
iss_op  out  OP_W
iss_pc  out  32
iss_tagx / iss_tagy / iss_tagw  out  TAG_W  always TAG_UNLOCKED when iss_busy
iss_datax / iss_datay  out  32
iss_target  out  5
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (rst_n low, async): all entries invalid, count=0, disp_ready=1, iss_busy=0, iss_* data/pc/op/target=0, iss_tag*=TAG_UNLOCKED.
- Storage: collapsing queue; index 0 oldest. Entry = valid, op, pc, tagx/datax, tagy/datay, tagw, target.
- disp_ready = (count < DEPTH), from registered state only; no same-cycle free-then-fill when full.
- Dispatch accepted when disp_valid && disp_ready && rdy && !flush; written at index count (count-1 if an issue happens same cycle).
- Dispatch capture bypass: if wb_en and a disp tag equals wb_tag (and is not TAG_UNLOCKED), store wb_data and TAG_UNLOCKED for that field.
- Wakeup: each cycle with wb_en, every valid entry field whose tag == wb_tag gets data=wb_data, tag=TAG_UNLOCKED (x, y; tagw cleared only). wb_tag==TAG_UNLOCKED never matches.
- Ready entry: valid and tagx, tagy, tagw all TAG_UNLOCKED, evaluated on registered state (wakeup visible next cycle).
- Issue: if rdy && !flush && alu_free && some ready entry: lowest-index ready entry k copied to iss_* registers, iss_busy=1 next cycle; entries k+1.. shift down one; count decrements (net 0 with simultaneous dispatch). Otherwise iss_busy=0 next cycle (iss data holds).
- Latency: dispatch with operands unlocked -> iss_busy earliest 2 cycles later (cycle N accept, N+1 in entry, N+2 iss_busy). Wakeup at cycle N -> issue visible N+2.
- Max one issue and one dispatch per cycle.
- flush (rdy high): next cycle all entries invalid, count=0, iss_busy=0; overrides dispatch, wakeup and issue same cycle.
- rdy low: all state and outputs hold; dispatch, wakeup, issue, flush ignored.
- Reset mid-operation: immediate clear as reset values; no partial issue.

Optional Feature:
ALU_RS_WAKE_BYPASS_EN: when defined, readiness also counts the same-cycle wakeup (tag == wb_tag with wb_en), issuing the woken entry with wb_data in that cycle; wakeup->iss_busy latency becomes 1 cycle. Undefined: readiness from registered state only (2 cycles), as above.

Test Plan:
- Reset, then dispatch ADD x=5,y=7 unlocked, tagw unlocked, alu_free=1 -> iss_busy=1 two cycles later with datax=5, datay=7, all iss_tag*=F, count back to 0.
- Dispatch A (tagx=3) then B (unlocked) -> B issues first; wb_en tag=3 data=0x10 -> A issues 2 cycles later with datax=0x10 (1 cycle with ALU_RS_WAKE_BYPASS_EN).
- Fill 4 entries all tagx=2 -> disp_ready=0, count=4; extra disp_valid ignored; wb tag 2 -> issues in order 0,1,2,3 on consecutive cycles, disp_ready=1 after first issue.
- Dispatch with tagy=6 in same cycle as wb_en tag=6 data=0xAB -> entry captures 0xAB, issues without further wakeup.
- 3 entries queued, flush=1 with simultaneous disp_valid -> next cycle count=0, iss_busy=0, nothing issued later.
- rdy=0 for 3 cycles with ready entry and alu_free=1 -> no issue, outputs held; rdy=1 -> issue resumes; assert rst_n low mid-sequence -> outputs at reset values immediately.
